// File: rtl/hx8352_bus_write_engine_if.sv
// Upstream word handshake plus HX8352 8080-style write bus, bundled for the write engine.
interface hx8352_bus_write_engine_if;
  // A word transfers on any rising clk edge where in_valid and in_ready are both 1;
  // in_valid/in_rs/in_data must stay stable while in_valid=1 and in_ready=0.
  logic        in_valid;
  logic        in_ready;
  logic        in_rs;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [15:0] lcd_data;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic        lcd_cs_n;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, done, lcd_data, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_cs_n
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, done, lcd_data, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_cs_n
  );
endinterface

// File: rtl/hx8352_bus_write_engine.sv
// Buffers {rs,data} words in a small FIFO and plays them onto an HX8352 parallel bus
// as timed SETUP / WR-low / WR-high write cycles, holding CS low across bursts.
module hx8352_bus_write_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int T_SETUP    = 1,
  parameter int T_WRL      = 2,
  parameter int T_WRH      = 2,
  parameter int CS_HOLD    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  hx8352_bus_write_engine_if.slave      bus,
  output logic [1:0]                    dbg_state
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] WRL_LD   = 8'(T_WRL - 1);
  localparam logic [7:0] WRH_LD   = 8'(T_WRH - 1);
  localparam logic [7:0] HOLD_LD  = 8'((CS_HOLD == 0) ? 0 : CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, WRL = 2'd2, WRH = 2'd3} state_t;

  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic          cs_n, cs_n_next;
  logic          pop, push;
  logic          rdy_en;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;
  logic [15:0]   data_q;
  logic          rs_q;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CW'(FIFO_DEPTH));
  // rdy_en keeps in_ready low during reset and until the first edge after release
  assign bus.in_ready = rdy_en & ~fifo_full;
  assign push         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cs_n  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cs_n  <= cs_n_next;
    end
  end

  // The single counter times SETUP/WRL/WRH and, in IDLE with CS low, the CS hold window.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cs_n_next  = cs_n;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cs_n_next  = 1'b0;
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end else if (!cs_n) begin
          if (cnt == 8'd0) cs_n_next = 1'b1;
          else             cnt_next  = cnt - 8'd1;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_next = WRL;
          cnt_next   = WRL_LD;
        end else cnt_next = cnt - 8'd1;
      end
      WRL: begin
        if (cnt == 8'd0) begin
          state_next = WRH;
          cnt_next   = WRH_LD;
        end else cnt_next = cnt - 8'd1;
      end
      WRH: begin
        if (cnt == 8'd0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETUP;
            cnt_next   = SETUP_LD;
          end else begin
            state_next = IDLE;
            cnt_next   = HOLD_LD;
            cs_n_next  = (CS_HOLD == 0);
          end
        end else cnt_next = cnt - 8'd1;
      end
    endcase
  end

  always_comb begin
    bus.lcd_wr_n = (state != WRL);
    bus.done     = (state == WRH) && (cnt == 8'd0);
    bus.busy     = !fifo_empty || (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= 16'd0;
      rs_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr][15:0];
        rs_q   <= mem[rd_ptr][16];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_rs, bus.in_data};
  end

  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_cs_n = cs_n;
  assign bus.lcd_rd_n = 1'b1;
  assign dbg_state    = state;
endmodule

// File: tb/tb_hx8352_bus_write_engine.sv
// Directed bench: default-timing engine (dut_a) and a stretched-timing, CS_HOLD=0 engine (dut_b).
module tb_hx8352_bus_write_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_rs = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        sel = 1'b0;
  logic        ready;
  logic [1:0]  dbg_a, dbg_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt_a = 0;
  int cs_hi_a    = 0;
  int done_cyc_a[$];
  logic [16:0] exp_q[$];
  logic [16:0] exp_b_q[$];

  hx8352_bus_write_engine_if a_if ();
  hx8352_bus_write_engine_if b_if ();

  assign a_if.in_valid = in_valid & ~sel;
  assign b_if.in_valid = in_valid & sel;
  assign a_if.in_rs    = in_rs;
  assign b_if.in_rs    = in_rs;
  assign a_if.in_data  = in_data;
  assign b_if.in_data  = in_data;
  assign ready = sel ? b_if.in_ready : a_if.in_ready;

  hx8352_bus_write_engine dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (a_if.slave),
    .dbg_state (dbg_a)
  );

  hx8352_bus_write_engine #(
    .T_SETUP (3),
    .T_WRL   (5),
    .T_WRH   (1),
    .CS_HOLD (0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (b_if.slave),
    .dbg_state (dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: every done pulse must present the oldest outstanding word
  always @(negedge clk) begin
    logic [16:0] e;
    if (a_if.lcd_cs_n) cs_hi_a++;
    if (a_if.done) begin
      done_cnt_a++;
      done_cyc_a.push_back(cyc);
      if (exp_q.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("a_word", {15'd0, a_if.lcd_rs, a_if.lcd_data}, {15'd0, e});
      end
    end
    if (b_if.done) begin
      if (exp_b_q.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        e = exp_b_q.pop_front();
        check("b_word", {15'd0, b_if.lcd_rs, b_if.lcd_data}, {15'd0, e});
      end
    end
  end

  // driver: called at a negedge, returns at the negedge after the accept edge
  task automatic push_word(input logic rs, input logic [15:0] d, output int stalls);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("push_timeout", 1, 0);
    else if (sel) exp_b_q.push_back({rs, d});
    else exp_q.push_back({rs, d});
    stalls = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(a_if.lcd_cs_n && !a_if.busy && b_if.lcd_cs_n && !b_if.busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int st, cs_snap, dn_snap, low;
    int dones[$];

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_if.in_ready, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_wr_n", a_if.lcd_wr_n, 1);
    check("rst_cs_n", a_if.lcd_cs_n, 1);
    check("rst_rd_n", a_if.lcd_rd_n, 1);
    check("rst_data", a_if.lcd_data, 0);
    check("rst_rs", a_if.lcd_rs, 0);
    check("rst_state", dbg_a, 0);
    rst = 1'b0;
    #1 check("ready_before_edge", a_if.in_ready, 0);
    @(negedge clk);
    check("ready_after_edge", a_if.in_ready, 1);
    check("b_rd_n", b_if.lcd_rd_n, 1);

    // single word with default timing
    push_word(1'b0, 16'h0083, st);
    check("t1_cs_p0", a_if.lcd_cs_n, 1);
    check("t1_busy_p0", a_if.busy, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t1_wr_n@%0d", k), a_if.lcd_wr_n, (k == 2 || k == 3) ? 0 : 1);
      check($sformatf("t1_done@%0d", k), a_if.done, (k == 5) ? 1 : 0);
      check($sformatf("t1_cs_n@%0d", k), a_if.lcd_cs_n, (k == 10) ? 1 : 0);
      check($sformatf("t1_busy@%0d", k), a_if.busy, (k <= 5) ? 1 : 0);
      if (k == 1) check("t1_data", a_if.lcd_data, 16'h0083);
    end
    check("t1_data_hold", {a_if.lcd_rs, a_if.lcd_data}, 17'h00083);

    // full-rate burst of 6 into a depth-4 FIFO
    done_cyc_a.delete();
    cs_snap = 0;
    for (int i = 0; i < 6; i++) begin
      push_word(i[0], 16'hA000 + 16'(i), st);
      check($sformatf("t2_stall%0d", i), st, (i == 5) ? 2 : 0);
      if (i == 1) cs_snap = cs_hi_a;
      if (i == 4) check("t2_ready_full", a_if.in_ready, 0);
    end
    st = 0;
    while (done_cyc_a.size() < 6 && st < 200) begin
      @(negedge clk);
      st++;
    end
    check("t2_done_count", done_cyc_a.size(), 6);
    check("t2_cs_low", cs_hi_a - cs_snap, 0);
    for (int i = 1; i < done_cyc_a.size(); i++)
      check($sformatf("t2_gap%0d", i), done_cyc_a[i] - done_cyc_a[i-1], 5);
    wait_idle();
    check("t2_queue_empty", exp_q.size(), 0);

    // new word two cycles into the CS hold window
    push_word(1'b0, 16'h1234, st);
    cs_snap = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) cs_snap = cs_hi_a;
      if (k >= 6) check($sformatf("t3_busy_hold@%0d", k), a_if.busy, 0);
    end
    push_word(1'b1, 16'h5678, st);
    check("t3_cs_held", cs_hi_a - cs_snap, 0);
    @(negedge clk);
    check("t3_data", a_if.lcd_data, 16'h5678);
    check("t3_rs", a_if.lcd_rs, 1);
    check("t3_cs_n", a_if.lcd_cs_n, 0);
    check("t3_state", dbg_a, 1);
    wait_idle();
    check("t3_queue_empty", exp_q.size(), 0);

    // reset in the middle of WRL with three words queued
    for (int i = 0; i < 4; i++) push_word(1'b0, 16'h0C00 + 16'(i), st);
    check("t4_state_wrl", dbg_a, 2);
    check("t4_wr_low", a_if.lcd_wr_n, 0);
    dn_snap = done_cnt_a;
    rst = 1'b1;
    #1;
    check("t4_wr_n", a_if.lcd_wr_n, 1);
    check("t4_cs_n", a_if.lcd_cs_n, 1);
    check("t4_busy", a_if.busy, 0);
    check("t4_ready", a_if.in_ready, 0);
    check("t4_done", a_if.done, 0);
    check("t4_data", a_if.lcd_data, 0);
    check("t4_state", dbg_a, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("t4_ready_pre_edge", a_if.in_ready, 0);
    @(negedge clk);
    check("t4_ready_post", a_if.in_ready, 1);
    check("t4_busy_post", a_if.busy, 0);
    repeat (10) @(negedge clk);
    check("t4_cs_stays_high", a_if.lcd_cs_n, 1);
    check("t4_busy_stays_low", a_if.busy, 0);
    check("t4_no_done", done_cnt_a - dn_snap, 0);

    // stretched timing, back-to-back rs=1 words, CS_HOLD=0
    sel = 1'b1;
    push_word(1'b1, 16'hB001, st);
    push_word(1'b1, 16'hB002, st);
    low = 0;
    for (int k = 1; k <= 19; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("t5_wr_n@%0d", k), b_if.lcd_wr_n,
            ((k >= 4 && k <= 8) || (k >= 13 && k <= 17)) ? 0 : 1);
      check($sformatf("t5_rs@%0d", k), b_if.lcd_rs, 1);
      if (k <= 9 && !b_if.lcd_wr_n) low++;
      if (b_if.done) dones.push_back(k);
      if (k == 9)  check("t5_data_wrh0", b_if.lcd_data, 16'hB001);
      if (k == 18) check("t5_data_wrh1", b_if.lcd_data, 16'hB002);
      if (k >= 18) check($sformatf("t5_cs_n@%0d", k), b_if.lcd_cs_n, (k == 19) ? 1 : 0);
    end
    check("t5_low_pulse", low, 5);
    check("t5_done_count", dones.size(), 2);
    if (dones.size() == 2) begin
      check("t5_first_done", dones[0], 9);
      check("t5_period", dones[1] - dones[0], 9);
    end
    check("t5_busy_end", b_if.busy, 0);
    sel = 1'b0;
    wait_idle();
    check("t5_queue_empty", exp_b_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hx8352_bus_write_engine.md
HX8352_BUS_WRITE_ENGINE -- requirements
Module: hx8352_bus_write_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered words (power of 2, 2..16).
REQ-002 SHALL have parameter T_SETUP, default 1, cycles data/RS/CS are stable before WR falls (1..255).
REQ-003 SHALL have parameter T_WRL, default 2, cycles lcd_wr_n is held low (1..255).
REQ-004 SHALL have parameter T_WRH, default 2, cycles lcd_wr_n is high with data held after the rising edge (1..255).
REQ-005 SHALL have parameter CS_HOLD, default 4, idle cycles before lcd_cs_n is released (0..255).
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  upstream word present.
REQ-009 in_ready  output  1  engine can accept a word.
REQ-010 in_rs  input  1  0 = command, 1 = data.
REQ-011 in_data  input  16  word to write.
REQ-012 busy  output  1  FIFO non-empty or write cycle in progress.
REQ-013 done  output  1  one-cycle pulse when a word's write cycle completes.
REQ-014 lcd_data  output  16  panel data bus.
REQ-015 lcd_rs  output  1  panel register-select.
REQ-016 lcd_wr_n  output  1  panel write strobe, active-low.
REQ-017 lcd_rd_n  output  1  panel read strobe, tied high.
REQ-018 lcd_cs_n  output  1  panel chip select, active-low.

Function
REQ-019 Transfer SHALL occur on any cycle with in_valid=1 and in_ready=1; {in_rs,in_data} is pushed into the FIFO.
REQ-020 in_ready SHALL equal NOT fifo_full; there is no push-while-pop bypass when full.
REQ-021 FSM states SHALL be IDLE, SETUP, WRL, WRH; one 8-bit down-counter times each state.
REQ-022 IDLE with FIFO non-empty: pop the head, load lcd_data/lcd_rs, drive lcd_cs_n=0, enter SETUP.
REQ-023 SETUP lasts T_SETUP cycles, then WRL; WRL drives lcd_wr_n=0 for T_WRL cycles, then WRH.
REQ-024 WRH drives lcd_wr_n=1 for T_WRH cycles with lcd_data/lcd_rs unchanged; on its last cycle done=1.
REQ-025 At the end of WRH: if the FIFO is non-empty, pop and go directly to SETUP (back-to-back, CS stays low); otherwise go to IDLE.
REQ-026 Per-word period SHALL be exactly T_SETUP+T_WRL+T_WRH cycles when back-to-back.
REQ-027 A word pushed into an empty FIFO while IDLE SHALL appear on lcd_data exactly 1 cycle after the accept edge.
REQ-028 lcd_data/lcd_rs SHALL change only on pop; they hold their last value in IDLE.
REQ-029 In IDLE with an empty FIFO, lcd_cs_n SHALL go high after CS_HOLD consecutive idle cycles (immediately when CS_HOLD=0).
REQ-030 A pop during the CS hold window SHALL cancel the release; lcd_cs_n stays low.
REQ-031 busy SHALL be 1 when the FIFO is non-empty or the state is not IDLE; the CS hold window does not count.
REQ-032 FIFO ordering SHALL be strict first-in, first-out; pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-033 lcd_rd_n SHALL be constant 1.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, FIFO empty, lcd_wr_n=1, lcd_cs_n=1, lcd_rd_n=1, lcd_data=0, lcd_rs=0, busy=0, done=0, in_ready=0.
REQ-035 in_ready SHALL go to 1 on the first clk edge after rst deasserts.
REQ-036 Reset during SETUP, WRL or WRH SHALL abort the cycle and discard buffered words, with no done pulse.

Verification
REQ-037 Single word with defaults: push {rs=0, 0x0083} -> cs_n low and data=0x0083 at +1; wr_n low for cycles +2..+3; done at +5; cs_n high at +10.
REQ-038 Burst of 6 words at full rate, depth 4 -> in_ready drops after 4 pending pushes; all 6 written in order, 5 cycles apart; cs_n stays low throughout.
REQ-039 Word arrives 2 cycles into the CS hold window -> cs_n never rises; the new write starts 1 cycle after the accept edge.
REQ-040 rst asserted mid-WRL with 3 words queued -> wr_n=1 and cs_n=1 asynchronously; no done pulse; after release, busy=0 and in_ready=1.
REQ-041 T_SETUP=3, T_WRL=5, T_WRH=1 -> measured low pulse is 5 cycles and period is 9 cycles; rs=1 is held through WRH.
